// File: rtl/myo_frame_pkg.sv
// Shared types and constants for the myocontrol frame SPI master.
// Frame layout offsets mirror the SAMD-side command structure.
package myo_frame_pkg;

  localparam int TX_BYTES_DEF = 89;
  localparam int RX_BYTES_DEF = 48;
  localparam int BYTE_BITS    = 8;

  localparam int OFS_KP           = 0;
  localparam int OFS_KI           = 8;
  localparam int OFS_KD           = 16;
  localparam int OFS_SP           = 24;
  localparam int OFS_OUT_POS_MAX  = 40;
  localparam int OFS_OUT_NEG_MAX  = 48;
  localparam int OFS_INT_POS_MAX  = 56;
  localparam int OFS_INT_NEG_MAX  = 64;
  localparam int OFS_DEADBAND     = 72;
  localparam int OFS_FLAGS        = 80;
  localparam int OFS_CONTROL_MODE = 81;
  localparam int OFS_OUT_DIVIDER  = 85;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SEL,
    ST_SHIFT,
    ST_DESEL,
    ST_GAP,
    ST_HOLD
  } state_e;

endpackage

// File: rtl/myo_frame_spi_master_spi_byte_shifter.sv
// One-byte SPI mode-0 shifter: SEL half, 16 SCK halves, then done.
// MSB first; MISO sampled on SCK rising, MOSI updated on SCK falling.
module spi_byte_shifter
  import myo_frame_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [7:0] data_i,
  input  logic       miso_i,
  output logic       sck_o,
  output logic       mosi_o,
  output logic       done_o,
  output logic [7:0] rx_o
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [4:0] LAST = 5'(2 * BYTE_BITS);

  logic [DW-1:0] div_q;
  logic [4:0]    half_q;
  logic          act_q;
  logic [7:0]    tx_q;
  logic [7:0]    rx_q;
  logic          sck_q;
  logic          mosi_q;
  logic          tick;

  assign tick   = act_q && (div_q == DW'(CLK_DIV - 1));
  assign done_o = tick && (half_q == LAST);
  assign sck_o  = sck_q;
  assign mosi_o = mosi_q;
  assign rx_o   = rx_q;

  // Half-period divider; even halves end in a rising edge, odd in a falling.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      div_q  <= '0;
      half_q <= '0;
      act_q  <= 1'b0;
      tx_q   <= '0;
      rx_q   <= '0;
      sck_q  <= 1'b0;
      mosi_q <= 1'b0;
    end else if (start_i) begin
      div_q  <= '0;
      half_q <= '0;
      act_q  <= 1'b1;
      tx_q   <= data_i;
      sck_q  <= 1'b0;
      mosi_q <= data_i[7];
    end else if (act_q) begin
      div_q <= tick ? '0 : div_q + 1'b1;
      if (tick) begin
        half_q <= half_q + 5'd1;
        if (half_q == LAST) begin
          act_q  <= 1'b0;
          mosi_q <= 1'b0;
        end else if (!half_q[0]) begin
          sck_q <= 1'b1;
          rx_q  <= {rx_q[6:0], miso_i};
        end else begin
          sck_q <= 1'b0;
          if (half_q != LAST - 5'd1) begin
            tx_q   <= tx_q << 1;
            mosi_q <= tx_q[6];
          end
        end
      end
    end
  end

endmodule

// File: rtl/myo_frame_spi_master.sv
// Frame-level SPI initiator: framing, TX/RX byte buffers, hold time.
// Bytes go out one per chip-select slot; replies land in the RX buffer.
module myo_frame_spi_master
  import myo_frame_pkg::*;
#(
  parameter int TX_BYTES  = TX_BYTES_DEF,
  parameter int RX_BYTES  = RX_BYTES_DEF,
  parameter int CLK_DIV   = 4,
  parameter int SETUP_CYC = 16,
  parameter int GAP_CYC   = 8,
  parameter int HOLD_CYC  = 1024
) (
  input  logic       iCLK,
  input  logic       iRESETn,
  input  logic       iSTART,
  output logic       oBUSY,
  output logic       oDONE,
  input  logic       iTX_WE,
  input  logic [6:0] iTX_ADDR,
  input  logic [7:0] iTX_DATA,
  input  logic [6:0] iRX_ADDR,
  output logic [7:0] oRX_DATA,
  output logic       oFRAME_n,
  output logic       oSPI_SS_n,
  output logic       oSPI_SCK,
  output logic       oSPI_MOSI,
  input  logic       iSPI_MISO
);

  localparam int CW  = 16;
  localparam int TAW = $clog2(TX_BYTES);
  localparam int RAW = $clog2(RX_BYTES);

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0]  idx_q, idx_d;
  logic        frame_q, frame_d;
  logic        ss_q, ss_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  rxd_q;
  logic        sh_start;
  logic        sh_done;
  logic        rx_we;
  logic        tx_wr;
  logic [7:0]  sh_rx;

  logic [7:0] tx_mem [TX_BYTES];
  logic [7:0] rx_mem [RX_BYTES];

  spi_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shift (
    .clk_i  (iCLK),
    .rst_ni (iRESETn),
    .start_i(sh_start),
    .data_i (tx_mem[idx_q[TAW-1:0]]),
    .miso_i (iSPI_MISO),
    .sck_o  (oSPI_SCK),
    .mosi_o (oSPI_MOSI),
    .done_o (sh_done),
    .rx_o   (sh_rx)
  );

  assign tx_wr = iRESETn && iTX_WE && !busy_q &&
                 (iTX_ADDR < 7'(TX_BYTES));

  // State and control registers.
  always_ff @(posedge iCLK) begin
    if (!iRESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      frame_q <= 1'b1;
      ss_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      ss_q    <= ss_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state: frame sequencing, byte slots and hold window.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    idx_d    = idx_q;
    frame_d  = frame_q;
    ss_d     = ss_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    sh_start = 1'b0;
    rx_we    = 1'b0;
    unique case (state_q)
      ST_IDLE: if (iSTART) begin
        state_d = ST_SETUP;
        cnt_d   = '0;
        idx_d   = '0;
        frame_d = 1'b0;
        busy_d  = 1'b1;
      end
      ST_SETUP: if (cnt_q == CW'(SETUP_CYC - 1)) begin
        state_d  = ST_SEL;
        cnt_d    = '0;
        ss_d     = 1'b0;
        sh_start = iRESETn;
      end
      ST_SEL: if (cnt_q == CW'(CLK_DIV - 1)) begin
        state_d = ST_SHIFT;
        cnt_d   = '0;
      end
      ST_SHIFT: if (sh_done) begin
        ss_d  = 1'b1;
        rx_we = iRESETn && (idx_q < 7'(RX_BYTES));
        idx_d = idx_q + 7'd1;
        cnt_d = '0;
        if (idx_q == 7'(TX_BYTES - 1)) begin
          state_d = ST_HOLD;
          frame_d = 1'b1;
          done_d  = 1'b1;
        end else begin
          state_d = ST_DESEL;
        end
      end
      ST_DESEL: state_d = ST_GAP;
      ST_GAP: if (cnt_q == CW'(GAP_CYC - 1)) begin
        state_d  = ST_SEL;
        cnt_d    = '0;
        ss_d     = 1'b0;
        sh_start = iRESETn;
      end
      ST_HOLD: if (cnt_q == CW'(HOLD_CYC - 1)) begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Byte buffers; contents survive reset.
  always_ff @(posedge iCLK) begin
    if (tx_wr) tx_mem[iTX_ADDR[TAW-1:0]] <= iTX_DATA;
    if (rx_we) rx_mem[idx_q[RAW-1:0]] <= sh_rx;
  end

  // Registered RX read port; out-of-range indices read as zero.
  always_ff @(posedge iCLK) begin
    if (!iRESETn) rxd_q <= '0;
    else if (iRX_ADDR < 7'(RX_BYTES)) rxd_q <= rx_mem[iRX_ADDR[RAW-1:0]];
    else rxd_q <= '0;
  end

  assign oBUSY     = busy_q;
  assign oDONE     = done_q;
  assign oFRAME_n  = frame_q;
  assign oSPI_SS_n = ss_q;
  assign oRX_DATA  = rxd_q;

endmodule

// File: tb/tb_myo_frame_spi_master.sv
// Scoreboard bench for myo_frame_spi_master.
// Bus monitor checks MOSI bytes and SCK timing; read monitor checks RX port.
module tb_myo_frame_spi_master;

  localparam int CLK_DIV = 4;
  localparam int NTX     = 89;
  localparam int NRX     = 48;

  logic       iCLK = 1'b0;
  logic       iRESETn = 1'b0;
  logic       iSTART = 1'b0;
  logic       oBUSY, oDONE;
  logic       iTX_WE = 1'b0;
  logic [6:0] iTX_ADDR = '0;
  logic [7:0] iTX_DATA = '0;
  logic [6:0] iRX_ADDR = '0;
  logic [7:0] oRX_DATA;
  logic       oFRAME_n, oSPI_SS_n, oSPI_SCK, oSPI_MOSI;
  logic       iSPI_MISO;

  logic       use_slave = 1'b0;
  logic       sl_miso = 1'b0;
  logic       rd_req = 1'b0;
  logic       rd_vld = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rd_q[$];

  assign iSPI_MISO = use_slave ? sl_miso : oSPI_MOSI;

  always #5 iCLK = ~iCLK;

  myo_frame_spi_master dut (
    .iCLK     (iCLK),
    .iRESETn  (iRESETn),
    .iSTART   (iSTART),
    .oBUSY    (oBUSY),
    .oDONE    (oDONE),
    .iTX_WE   (iTX_WE),
    .iTX_ADDR (iTX_ADDR),
    .iTX_DATA (iTX_DATA),
    .iRX_ADDR (iRX_ADDR),
    .oRX_DATA (oRX_DATA),
    .oFRAME_n (oFRAME_n),
    .oSPI_SS_n(oSPI_SS_n),
    .oSPI_SCK (oSPI_SCK),
    .oSPI_MOSI(oSPI_MOSI),
    .iSPI_MISO(iSPI_MISO)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Read-valid tracks the registered read latency.
  initial forever begin
    @(posedge iCLK);
    rd_vld = rd_req;
  end

  bit         pss = 1'b1;
  bit         psck = 1'b0;
  bit         pfr = 1'b1;
  int         run = 0;
  int         bits = 0;
  int         sl_idx = 0;
  logic [7:0] cap = '0;
  logic [7:0] sl_sh = '0;
  logic [7:0] e;

  // Monitor: SPI bus scoreboard, slave reply model, RX read scoreboard.
  initial forever begin
    @(negedge iCLK);
    if (pss && !oSPI_SS_n) begin
      run = 1;
      bits = 0;
    end else if (!pss && oSPI_SS_n) begin
      if (bits == 8) begin
        chk("sck_tail", run, CLK_DIV);
        if (exp_q.size() == 0) chk("mosi_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("mosi_byte", cap, e);
        end
      end
    end else if (!oSPI_SS_n) begin
      if (oSPI_SCK == psck) run++;
      else begin
        chk("sck_run", run, CLK_DIV);
        run = 1;
        if (oSPI_SCK) begin
          cap = {cap[6:0], oSPI_MOSI};
          bits++;
        end
      end
    end
    if (pfr && !oFRAME_n) sl_idx = 0;
    if (pss && !oSPI_SS_n) begin
      sl_sh = 8'h80 + 8'(sl_idx);
      sl_miso = sl_sh[7];
    end else if (!oSPI_SS_n && psck && !oSPI_SCK) begin
      sl_sh = {sl_sh[6:0], 1'b0};
      sl_miso = sl_sh[7];
    end
    if (!pss && oSPI_SS_n) sl_idx++;
    if (rd_vld) begin
      if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
      else begin
        e = rd_q.pop_front();
        chk("rx_read", oRX_DATA, e);
      end
    end
    pss = oSPI_SS_n;
    psck = oSPI_SCK;
    pfr = oFRAME_n;
  end

  task automatic push_frame(input logic [7:0] b0);
    for (int k = 0; k < NTX; k++) exp_q.push_back(k == 0 ? b0 : 8'(k));
  endtask

  task automatic rd(input int a, input int ex);
    iRX_ADDR = 7'(a);
    rd_req = 1'b1;
    rd_q.push_back(8'(ex));
    @(negedge iCLK);
  endtask

  task automatic rd_drain();
    rd_req = 1'b0;
    repeat (3) @(negedge iCLK);
    chk("rd_q_empty", rd_q.size(), 0);
  endtask

  // Runs from the cycle after a start is accepted until oBUSY drops.
  task automatic frame_body(input bit chain);
    int k, done_at, busy_end, dones, low_cnt;
    chk("start_frame_n", oFRAME_n, 0);
    chk("start_busy", oBUSY, 1);
    k = 0;
    done_at = -1;
    busy_end = -1;
    dones = 0;
    low_cnt = 1;
    while (k < 9000) begin
      @(negedge iCLK);
      k++;
      iSTART = 1'b0;
      iTX_WE = 1'b0;
      if (oDONE) begin
        dones++;
        if (done_at < 0) begin
          done_at = k;
          chk("done_frame_hi", oFRAME_n, 1);
        end
      end
      if (!oFRAME_n) low_cnt++;
      if (!oBUSY) begin
        busy_end = k;
        break;
      end
      if (k == 3000 || k == 7000) iSTART = 1'b1;
      if (k == 3500) begin
        iTX_WE = 1'b1;
        iTX_ADDR = 7'd80;
        iTX_DATA = 8'hEE;
      end
      if (chain && k == 7795) begin
        iSTART = 1'b1;
        iTX_WE = 1'b1;
        iTX_ADDR = 7'd0;
        iTX_DATA = 8'h5A;
      end
    end
    chk("done_latency", done_at, 6772);
    chk("done_pulses", dones, 1);
    chk("frame_low_len", low_cnt, 6772);
    chk("busy_len", busy_end, 7796);
    chk("mosi_q_empty", exp_q.size(), 0);
  endtask

  initial begin
    int falls, w;
    bit ps;
    repeat (3) @(negedge iCLK);
    chk("rst_frame", oFRAME_n, 1);
    chk("rst_ss", oSPI_SS_n, 1);
    chk("rst_sck", oSPI_SCK, 0);
    chk("rst_mosi", oSPI_MOSI, 0);
    chk("rst_busy", oBUSY, 0);
    chk("rst_done", oDONE, 0);
    chk("rst_rxdata", oRX_DATA, 0);
    iRESETn = 1'b1;
    @(negedge iCLK);

    for (int k = 0; k < NTX; k++) begin
      iTX_WE = 1'b1;
      iTX_ADDR = 7'(k);
      iTX_DATA = 8'(k);
      @(negedge iCLK);
    end
    iTX_WE = 1'b0;

    push_frame(8'h00);
    iSTART = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0;
    frame_body(1'b0);

    for (int k = 0; k < NRX; k++) rd(k, k);
    rd(48, 0);
    rd(100, 0);
    rd(127, 0);
    rd_drain();

    use_slave = 1'b1;
    push_frame(8'hA5);
    iSTART = 1'b1;
    iTX_WE = 1'b1;
    iTX_ADDR = 7'd0;
    iTX_DATA = 8'hA5;
    @(negedge iCLK);
    iSTART = 1'b0;
    iTX_WE = 1'b0;
    frame_body(1'b0);

    for (int k = 0; k < NRX; k++) rd(k, 8'h80 + k);
    rd(48, 0);
    rd_drain();

    use_slave = 1'b0;
    push_frame(8'hA5);
    iSTART = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0;
    falls = 0;
    w = 0;
    ps = 1'b1;
    while (falls < 41 && w < 6000) begin
      @(negedge iCLK);
      w++;
      if (ps && !oSPI_SS_n) falls++;
      ps = oSPI_SS_n;
    end
    chk("byte40_reached", falls, 41);
    repeat (20) @(negedge iCLK);
    iRESETn = 1'b0;
    @(negedge iCLK);
    chk("mid_rst_frame", oFRAME_n, 1);
    chk("mid_rst_ss", oSPI_SS_n, 1);
    chk("mid_rst_sck", oSPI_SCK, 0);
    chk("mid_rst_mosi", oSPI_MOSI, 0);
    chk("mid_rst_busy", oBUSY, 0);
    chk("mid_rst_done", oDONE, 0);
    chk("mid_rst_rxdata", oRX_DATA, 0);
    iRESETn = 1'b1;
    exp_q.delete();
    push_frame(8'hA5);
    iSTART = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0;
    frame_body(1'b1);

    iSTART = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0;
    chk("restart_frame_n", oFRAME_n, 0);
    chk("restart_busy", oBUSY, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
